subbank_line_reader: RTL and testbench

//  Read-side streamer for one sub-bank. It sits directly downstream of the 400-bit
//  sub-bank memory (1W/1R, 1-cycle registered read).
//  It accepts a burst command (base, length) and issues sequential line reads,

---
 rtl/subbank_pkg.sv | 40 ++++
 rtl/subbank_line_reader_fifo.sv | 58 +++++
 rtl/subbank_line_reader.sv | 157 +++++++++++++++
 tb/tb_subbank_line_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subbank_pkg.sv
// Purpose : shared sub-bank constants, line payload type and segment math.
//           The sub-bank memory imports the same functions so that its output
//           mux and this reader agree on which URAM/BRAM segment an address hits.
// Contents: geometry localparams, line_t payload, reader state enum,
//           div_ceil(a,b), seg_idx(addr,seg).
package subbank_pkg;

    localparam int unsigned COEFF_BITS       = 50;
    localparam int unsigned COEFFS_PER_BLOCK = 8;
    localparam int unsigned LINE_WIDTH       = COEFF_BITS * COEFFS_PER_BLOCK;
    localparam int unsigned DEPTH            = 1024;
    localparam int unsigned URAM_TILES       = 3;
    localparam int unsigned BRAM18_TILES     = 13;
    localparam int unsigned AW               = $clog2(DEPTH);

    function automatic int unsigned div_ceil(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Depth of one URAM / BRAM segment; the last segment may be short.
    localparam int unsigned USEG = div_ceil(DEPTH, URAM_TILES);
    localparam int unsigned BSEG = div_ceil(DEPTH, BRAM18_TILES);

    function automatic int unsigned seg_idx(input logic [AW-1:0] addr, input int unsigned seg);
        return 32'(addr) / seg;
    endfunction

    typedef struct packed {
        logic                  last;
        logic [LINE_WIDTH-1:0] data;
    } line_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ZERO  = 2'd3
    } state_t;

endpackage

// File: rtl/subbank_line_reader_fifo.sv
// Purpose : 2-entry line FIFO with a registered head entry.
// Ports   : clk, rst (sync, active-high)
//           i_push/i_din  write side (line + last tag)
//           i_pop         read side, ignored when empty
//           o_head        current head entry
//           o_count       occupancy 0..2
module line_fifo2
    import subbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  line_t      i_din,
    input  logic       i_pop,
    output line_t      o_head,
    output logic [1:0] o_count
);

    line_t      r_head;
    line_t      r_tail;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    // Head always holds the oldest entry; tail only used at occupancy 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_push && w_pop) begin
            if (r_count == 2'd2) begin
                r_head <= r_tail;
                r_tail <= i_din;
            end else begin
                r_head <= i_din;
            end
        end else if (i_push) begin
            if (r_count == 2'd0) begin
                r_head <= i_din;
            end else begin
                r_tail <= i_din;
            end
            r_count <= r_count + 2'd1;
        end else if (w_pop) begin
            r_head  <= r_tail;
            r_count <= r_count - 2'd1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_count == 2'd2) && !i_pop));

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/subbank_line_reader.sv
// Purpose : read-side burst streamer for one sub-bank (1-cycle registered read,
//           output mux steered by the live read address).
// Ports   : clk, rst (sync, active-high)
//           cmd_valid/cmd_ready/cmd_base/cmd_len  burst command (len 0..DEPTH)
//           mem_re/mem_raddr/mem_rdata            sub-bank read port
//           out_valid/out_ready/out_data/out_last line stream
//           busy, done                            status; done pulses at burst end
module subbank_line_reader
    import subbank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_base,
    input  logic [AW:0]           cmd_len,
    output logic                  mem_re,
    output logic [AW-1:0]         mem_raddr,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LINE_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned AW1 = AW + 1;

    state_t          r_state;
    logic [AW-1:0]   r_raddr;
    logic            r_armed;
    logic [AW1-1:0]  r_remaining;
    logic            r_inflight;
    logic            r_inflight_last;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_count;
    line_t           w_head;
    line_t           w_fifo_in;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_issue;
    logic [AW-1:0]   w_next_addr;
    logic            w_at_end;
    logic            w_same_seg;

    assign w_pop = out_valid && out_ready;

    // Lines that will sit in the FIFO after this cycle, not counting a new issue.
    assign w_occ = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);

    // r_raddr is presented before the issue, so an issue only needs the
    // address to be armed and FIFO room for the returning line.
    assign w_issue = (r_state == ST_RUN) && r_armed && (w_occ < 3'd2);

    assign w_at_end    = (r_raddr == AW'(DEPTH - 1));
    assign w_next_addr = w_at_end ? '0 : r_raddr + AW'(1);

    // Next address may go live during the capture cycle only if it selects the
    // same URAM and BRAM segment as the read in flight; the wrap always waits.
    assign w_same_seg = !w_at_end &&
                        (seg_idx(w_next_addr, USEG) == seg_idx(r_raddr, USEG)) &&
                        (seg_idx(w_next_addr, BSEG) == seg_idx(r_raddr, BSEG));

    // Control FSM with address/length counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_raddr         <= '0;
            r_armed         <= 1'b0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == AW1'(1));
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len != '0) begin
                            r_state     <= ST_RUN;
                            r_raddr     <= cmd_base;
                            r_armed     <= 1'b1;
                            r_remaining <= cmd_len;
                        end else begin
                            r_state <= ST_ZERO;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_ZERO: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_remaining <= r_remaining - AW1'(1);
                        if (r_remaining == AW1'(1)) begin
                            r_state <= ST_DRAIN;
                            r_armed <= 1'b0;
                        end else if (w_same_seg) begin
                            r_raddr <= w_next_addr;
                        end else begin
                            // Hold the address through the capture cycle (bubble).
                            r_armed <= 1'b0;
                        end
                    end else if (!r_armed) begin
                        r_raddr <= w_next_addr;
                        r_armed <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_fifo_in.last = r_inflight_last;
    assign w_fifo_in.data = mem_rdata;

    line_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (w_fifo_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_re    = w_issue;
    assign mem_raddr = r_raddr;
    assign out_valid = (w_count != 2'd0);
    assign out_data  = w_head.data;
    assign out_last  = w_head.last;

endmodule

// File: tb/tb_subbank_line_reader.sv
// Purpose : scoreboard bench for subbank_line_reader with a behavioural sub-bank
//           whose output mux follows the live read address.
module tb_subbank_line_reader;
    import subbank_pkg::*;

    localparam int TB_DEPTH = 1024;
    localparam int TB_USEG  = 342;
    localparam int TB_BSEG  = 79;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [AW-1:0]         cmd_base = '0;
    logic [AW:0]           cmd_len = '0;
    logic                  mem_re;
    logic [AW-1:0]         mem_raddr;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [LINE_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;

    typedef struct {
        logic [LINE_WIDTH-1:0] data;
        logic                  last;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;
    int   issue_addr[$];
    int   issue_cyc[$];

    logic [LINE_WIDTH-1:0] m_word = '0;
    int                    m_u = -1;
    int                    m_b = -1;

    subbank_line_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LINE_WIDTH-1:0] line_of(input int a);
        logic [LINE_WIDTH-1:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*50 +: 50] = {16'hBEEF, 20'(a), 14'(k)};
        return l;
    endfunction

    // Sub-bank: registered read per segment, output picked by the live address.
    always @(posedge clk) begin
        if (mem_re) begin
            m_word <= line_of(int'(mem_raddr));
            m_u    <= int'(mem_raddr) / TB_USEG;
            m_b    <= int'(mem_raddr) / TB_BSEG;
        end
    end
    assign mem_rdata = ((int'(mem_raddr) / TB_USEG == m_u) && (int'(mem_raddr) / TB_BSEG == m_b))
                       ? m_word : ~m_word;

    // Monitor: pops the scoreboard on every handshake, logs issues and done pulses.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_line: got line with last=%0b, expected none", out_last);
            end else begin
                sb_e = sb_q.pop_front();
                if (out_data !== sb_e.data || out_last !== sb_e.last) begin
                    bad++;
                    $display("FAIL line: got data=%h last=%0b expected data=%h last=%0b",
                             out_data, out_last, sb_e.data, sb_e.last);
                end
            end
            pop_cnt++;
            if (out_last) last_pop_cyc = cyc;
        end
        if (mem_re) begin
            issue_addr.push_back(int'(mem_raddr));
            issue_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        issue_addr.delete();
        issue_cyc.delete();
    endtask

    task automatic send_cmd(input int base, input int len, input bit track);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        if (track) begin
            for (int i = 0; i < len; i++)
                sb_q.push_back('{line_of((base + i) % TB_DEPTH), (i == len - 1)});
        end
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || !cmd_ready || sb_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    // Issue log against expected addresses; gap of one cycle after index bubble_after.
    task automatic check_issues(input string tag, input int base, input int n,
                                input int bubble_after, input bit timing);
        check({tag, "_issue_count"}, issue_addr.size(), n);
        if (issue_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_issue_addr"}, issue_addr[i], (base + i) % TB_DEPTH);
                if (timing)
                    check({tag, "_issue_cyc"}, issue_cyc[i] - issue_cyc[0],
                          i + ((bubble_after >= 0 && i > bubble_after) ? 1 : 0));
            end
        end
    endtask

    initial begin
        int d0;
        int p0;
        int w;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_mem_re", int'(mem_re), 0);
        check("rst_mem_raddr", int'(mem_raddr), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: in-segment burst, full throughput
        out_ready = 1'b1;
        clear_log();
        d0 = done_cnt;
        send_cmd(0, 8, 1'b1);
        wait_idle("t1", 200);
        check_issues("t1", 0, 8, -1, 1'b1);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_done_after_pop", done_cyc - last_pop_cyc, 1);

        // 2: URAM segment boundary 341->342 costs one bubble
        clear_log();
        send_cmd(340, 4, 1'b1);
        wait_idle("t2", 200);
        check_issues("t2", 340, 4, 1, 1'b1);

        // 3: wrap 1023->0 bubbles, last on addr 1
        clear_log();
        send_cmd(1022, 4, 1'b1);
        wait_idle("t3", 200);
        check_issues("t3", 1022, 4, 1, 1'b1);

        // 4: backpressure stalls after two reads, commands ignored while busy
        out_ready = 1'b0;
        clear_log();
        send_cmd(500, 16, 1'b1);
        repeat (20) @(negedge clk);
        check("t4_stalled_issues", issue_addr.size(), 2);
        check("t4_busy_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = AW'(7);
        cmd_len   = (AW+1)'(3);
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("t4", 400);
        check_issues("t4", 500, 16, -1, 1'b0);

        // 5: zero-length burst
        clear_log();
        d0 = done_cnt;
        send_cmd(5, 0, 1'b0);
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 5) begin
            @(negedge clk);
            w++;
        end
        check("t5_ready_within_2", int'(w < 2), 1);
        repeat (4) @(negedge clk);
        check("t5_no_reads", issue_addr.size(), 0);
        check("t5_done_once", done_cnt - d0, 1);

        // 6: reset mid-burst, then a wrapping burst
        clear_log();
        p0 = pop_cnt;
        send_cmd(100, 10, 1'b1);
        w = 0;
        while (pop_cnt - p0 < 5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("t6_reached_5", int'(pop_cnt - p0 >= 5), 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_cmd_ready", int'(cmd_ready), 1);
        check("t6_mem_re", int'(mem_re), 0);
        repeat (5) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        clear_log();
        send_cmd(1020, 6, 1'b1);
        wait_idle("t6b", 200);
        check_issues("t6b", 1020, 6, 3, 1'b1);
        check("t6b_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

endmodule
